// File: rtl/systolic_matmul_engine.sv
// systolic_matmul_engine
// Computes C = A*B on an output-stationary grid of A_ROWS x B_COLS MAC cells.
// A and B are loaded through a runtime write port. Each run is launched by a
// start/busy/done handshake and can optionally accumulate onto the previous C.
// C is read back through a registered read port.
//
// Ports:
//   clk, reset        single clock; synchronous active-high reset
//   wr_en/wr_sel      operand write strobe; 0 selects A, 1 selects B
//   wr_addr/wr_data   row-major element index and operand value
//   start/accumulate  launch request (IDLE only); keep-and-add mode bit
//   busy/done         run in progress; one-cycle completion pulse
//   rd_addr/rd_data   row-major C index; registered C element (1-cycle lag)
module systolic_matmul_engine #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned A_ROWS     = 2,
  parameter int unsigned A_COLS     = 2,
  parameter int unsigned B_COLS     = 2,
  parameter int unsigned SIGNED     = 0,
  parameter int unsigned ACC_WIDTH  = 2*DATA_WIDTH + $clog2(A_COLS),
  parameter int unsigned AW         = $clog2((A_ROWS*A_COLS > A_COLS*B_COLS)
                                      ? ((A_ROWS*A_COLS > 1) ? A_ROWS*A_COLS : 2)
                                      : ((A_COLS*B_COLS > 1) ? A_COLS*B_COLS : 2)),
  parameter int unsigned RW         = $clog2((A_ROWS*B_COLS > 1) ? A_ROWS*B_COLS : 2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  accumulate,
  output logic                  busy,
  output logic                  done,
  input  logic [RW-1:0]         rd_addr,
  output logic [ACC_WIDTH-1:0]  rd_data
);

  localparam int unsigned PW = 2*DATA_WIDTH;
  localparam int unsigned S  = A_ROWS + A_COLS + B_COLS - 2;
  localparam int unsigned KW = $clog2(S + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [KW-1:0]         step_q, step_d;
  logic                  busy_d, done_d;
  logic                  acc_mode_q;
  logic                  mac_en_c;

  logic [DATA_WIDTH-1:0] a_buf [A_ROWS][A_COLS];
  logic [DATA_WIDTH-1:0] b_buf [A_COLS][B_COLS];
  logic [DATA_WIDTH-1:0] a_feed_c [A_ROWS];
  logic [DATA_WIDTH-1:0] b_feed_c [B_COLS];
  logic [DATA_WIDTH-1:0] a_fwd [A_ROWS][B_COLS];
  logic [DATA_WIDTH-1:0] b_fwd [A_ROWS][B_COLS];
  logic [ACC_WIDTH-1:0]  acc_all [A_ROWS][B_COLS];
  logic [ACC_WIDTH-1:0]  rd_c;

  // Full-width product extended to the accumulator width.
  function automatic logic [ACC_WIDTH-1:0] mac_term(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [PW-1:0] p;
    if (SIGNED != 0) begin
      p = PW'($signed(a)) * PW'($signed(b));
      return ACC_WIDTH'($signed(p));
    end
    p = PW'(a) * PW'(b);
    return ACC_WIDTH'(p);
  endfunction

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      step_q     <= '0;
      acc_mode_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      busy    <= busy_d;
      done    <= done_d;
      if (state_q == IDLE && start) acc_mode_q <= accumulate;
    end
  end

  // Next state. done is registered on the DRAIN->IDLE transition, so the FSM
  // is already idle during the done cycle and can take the next start there.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: begin
        state_d = FEED;
        step_d  = '0;
      end
      FEED: begin
        if (step_q == KW'(S - 1)) begin
          state_d = DRAIN;
          step_d  = '0;
        end else begin
          step_d = step_q + KW'(1);
        end
      end
      DRAIN: begin
        if (step_q == KW'(1)) begin
          state_d = IDLE;
          step_d  = '0;
          done_d  = 1'b1;
        end else begin
          step_d = step_q + KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Operand buffers; out-of-range addresses match no element and are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < A_ROWS; i++)
        for (int m = 0; m < A_COLS; m++) a_buf[i][m] <= '0;
      for (int m = 0; m < A_COLS; m++)
        for (int j = 0; j < B_COLS; j++) b_buf[m][j] <= '0;
    end else if (wr_en && state_q == IDLE) begin
      for (int i = 0; i < A_ROWS; i++)
        for (int m = 0; m < A_COLS; m++)
          if (!wr_sel && wr_addr == AW'(i*A_COLS + m)) a_buf[i][m] <= wr_data;
      for (int m = 0; m < A_COLS; m++)
        for (int j = 0; j < B_COLS; j++)
          if (wr_sel && wr_addr == AW'(m*B_COLS + j)) b_buf[m][j] <= wr_data;
    end
  end

  // Skewed edge feeders: row i lags by i steps, column j by j steps.
  always_comb begin
    for (int i = 0; i < A_ROWS; i++) begin
      a_feed_c[i] = '0;
      for (int m = 0; m < A_COLS; m++)
        if (state_q == FEED && int'(step_q) == i + m) a_feed_c[i] = a_buf[i][m];
    end
    for (int j = 0; j < B_COLS; j++) begin
      b_feed_c[j] = '0;
      for (int m = 0; m < A_COLS; m++)
        if (state_q == FEED && int'(step_q) == j + m) b_feed_c[j] = b_buf[m][j];
    end
  end

  assign mac_en_c = (state_q == FEED) || (state_q == DRAIN);

  // MAC grid: a flows right, b flows down, acc stays in place.
  for (genvar gi = 0; gi < A_ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < B_COLS; gj++) begin : g_col
      logic [DATA_WIDTH-1:0] a_in, b_in, a_q, b_q;
      logic [ACC_WIDTH-1:0]  acc_q;

      if (gj == 0) begin : g_a_edge
        assign a_in = a_feed_c[gi];
      end else begin : g_a_link
        assign a_in = a_fwd[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign b_in = b_feed_c[gj];
      end else begin : g_b_link
        assign b_in = b_fwd[gi-1][gj];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else if (state_q == CLEAR) begin
          a_q <= '0;
          b_q <= '0;
          if (!acc_mode_q) acc_q <= '0;
        end else if (mac_en_c) begin
          a_q   <= a_in;
          b_q   <= b_in;
          acc_q <= acc_q + mac_term(a_in, b_in);
        end
      end

      assign a_fwd[gi][gj]   = a_q;
      assign b_fwd[gi][gj]   = b_q;
      assign acc_all[gi][gj] = acc_q;
    end
  end

  // Result select; addresses past the last element read as zero.
  always_comb begin
    rd_c = '0;
    for (int i = 0; i < A_ROWS; i++)
      for (int j = 0; j < B_COLS; j++)
        if (rd_addr == RW'(i*B_COLS + j)) rd_c = acc_all[i][j];
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_c;
  end

endmodule
